// File: rtl/toggle_counter_pkg.sv
// Shared definitions for toggle_counter.
//   mode_e : operating mode encoding carried on the 2-bit mode port.
package toggle_counter_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

endpackage : toggle_counter_pkg

// File: rtl/tff_cell.sv
// Single toggle flip-flop cell.
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset, loads rst_val
//   t       : toggle request; q inverts at the edge when high
//   rst_val : value taken by q during reset
//   q       : cell state
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  input  logic rst_val,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (t) q_d = ~q_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= rst_val;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule : tff_cell

// File: rtl/toggle_counter.sv
// WIDTH-bit counter/divider built from per-bit toggle cells.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (q = RESET_VAL, wrap = 0)
//   en    : state-update enable; q holds and wrap clears when low
//   mode  : 00 toggle bank, 01 modulo up, 10 modulo down, 11 load
//   t     : toggle mask (toggle mode) or load data (load mode)
//   q     : register state
//   qbar  : ~q, combinational from q
//   wrap  : registered one-cycle pulse coinciding with a wrapped q
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter longint unsigned  MODULUS   = 16,
  parameter int unsigned      RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             wrap
);

  // Comparisons run at WIDTH+1 bits so MODULUS = 2^WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_cells;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] tv;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   t_ext;
  logic             wrap_d;
  logic             wrap_q;

  always_comb begin
    q_ext  = {1'b0, q_cells};
    t_ext  = {1'b0, t};
    next_q = q_cells;
    wrap_d = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_TOGGLE: next_q = q_cells ^ t;
        MODE_UP: begin
          if (q_ext >= MAX_W) begin
            next_q = '0;
            wrap_d = 1'b1;
          end else begin
            next_q = q_cells + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (q_cells == '0) begin
            next_q = MAX_Q;
            wrap_d = 1'b1;
          end else if (q_ext >= MOD_W) begin
            // Out-of-range state left by toggle mode: recover without a wrap.
            next_q = MAX_Q;
          end else begin
            next_q = q_cells - WIDTH'(1);
          end
        end
        MODE_LOAD: next_q = (t_ext < MOD_W) ? t : MAX_Q;
      endcase
    end
  end

  // Every mode is realised by toggling exactly the bits that must change.
  assign tv = q_cells ^ next_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .t       (tv[i]),
      .rst_val (RST_Q[i]),
      .q       (q_cells[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign q    = q_cells;
  assign qbar = ~q_cells;
  assign wrap = wrap_q;

endmodule : toggle_counter
